// File: rtl/fan_pwm_tach_ctrl.sv
// ---------------------------------------------------------------------------
// fan_pwm_tach_ctrl
//
// Fan control stage for the control-board top wrapper. It drives one PWM pin
// shared by all fan headers and measures the six fan tachometer inputs.
//
//   * PWM: a prescaler and step counter build a period of
//     (PWM_TOP+1)*PWM_PRESCALE cycles. The software duty is captured on
//     i_duty_we and applied only at a period boundary, so the output never
//     produces a runt pulse.
//   * Tach: every fan input is synchronised, falling edges are counted over a
//     fixed gate window of GATE_CYCLES cycles, and the saturated per-fan
//     counts are published with a stall flag at the end of each window.
//   * Watchdog: if software stops writing the duty for WDOG_GATES windows,
//     the fans are forced to full speed until the next write.
//   * Reset forces the PWM pin high (full speed).
//
// Ports:
//   i_aclk          system clock
//   i_aresetn       asynchronous active-low reset
//   i_duty[7:0]     requested duty in PWM steps (>= PWM_TOP+1 means 100%)
//   i_duty_we       one-cycle write strobe for i_duty, also feeds the watchdog
//   i_min_cnt[15:0] stall threshold in falling edges per gate window
//   i_fan_speed[5:0] asynchronous tach inputs, one per fan
//   o_fan_pwm       PWM to the fan headers, 1 = drive
//   o_tach_cnt[95:0] six 16-bit edge counts, fan i in bits [16i+15:16i]
//   o_tach_valid    one-cycle pulse when o_tach_cnt / o_fan_fault update
//   o_fan_fault[5:0] per-fan stall flag
//   o_wdog_expired  watchdog expired, full speed is being forced
// ---------------------------------------------------------------------------
module fan_pwm_tach_ctrl #(
    parameter int PWM_PRESCALE = 16,
    parameter int PWM_TOP      = 249,
    parameter int GATE_CYCLES  = 100000000,
    parameter int WDOG_GATES   = 3
) (
    input  logic        i_aclk,
    input  logic        i_aresetn,
    input  logic [7:0]  i_duty,
    input  logic        i_duty_we,
    input  logic [15:0] i_min_cnt,
    input  logic [5:0]  i_fan_speed,
    output logic        o_fan_pwm,
    output logic [95:0] o_tach_cnt,
    output logic        o_tach_valid,
    output logic [5:0]  o_fan_fault,
    output logic        o_wdog_expired
);

    localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int WW = $clog2(WDOG_GATES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_PRESCALE - 1);
    localparam logic [8:0]    STEP_LAST  = 9'(PWM_TOP);
    localparam logic [8:0]    DUTY_FULL  = 9'(PWM_TOP + 1);
    localparam logic [GW-1:0] GATE_LAST  = GW'(GATE_CYCLES - 1);
    localparam logic [WW-1:0] WDOG_LIMIT = WW'(WDOG_GATES);

    // Any duty at or above PWM_TOP+1 behaves as 100%.
    function automatic logic [8:0] clamp_duty(input logic [7:0] d);
        logic [8:0] dx;
        dx = {1'b0, d};
        return (dx > DUTY_FULL) ? DUTY_FULL : dx;
    endfunction

    // Edge accumulator that sticks at full scale instead of wrapping.
    function automatic logic [15:0] sat16(input logic [15:0] a, input logic inc);
        return (inc && (a != 16'hFFFF)) ? a + 16'd1 : a;
    endfunction

    // -----------------------------------------------------------------------
    // PWM timebase and duty registers
    // -----------------------------------------------------------------------
    logic [PW-1:0] presc_cnt;
    logic [8:0]    step_cnt;
    logic [7:0]    duty_req;
    logic [7:0]    duty_act;
    logic          presc_wrap;
    logic          period_end;
    logic [8:0]    duty_eff;

    always_comb begin
        presc_wrap = (presc_cnt == PRESC_LAST);
        period_end = presc_wrap && (step_cnt == STEP_LAST);
        duty_eff   = clamp_duty(duty_act);
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            presc_cnt <= '0;
            step_cnt  <= '0;
            duty_req  <= 8'hFF;
            duty_act  <= 8'hFF;
            o_fan_pwm <= 1'b1;
        end else begin
            if (presc_wrap) begin
                presc_cnt <= '0;
                step_cnt  <= period_end ? 9'd0 : step_cnt + 9'd1;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end

            if (i_duty_we) begin
                duty_req <= i_duty;
            end

            // Duty only changes on a period boundary; the watchdog overrides
            // whatever software last asked for.
            if (period_end) begin
                duty_act <= o_wdog_expired ? 8'hFF : duty_req;
            end

            o_fan_pwm <= (step_cnt < duty_eff);
        end
    end

    // -----------------------------------------------------------------------
    // Tach synchroniser (_p0, _p1) and history (_p2) for edge detection
    // -----------------------------------------------------------------------
    logic [5:0] sync_p0;
    logic [5:0] sync_p1;
    logic [5:0] hist_p2;
    logic [5:0] fall;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            hist_p2 <= '0;
        end else begin
            sync_p0 <= i_fan_speed;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
        end
    end

    assign fall = hist_p2 & ~sync_p1;

    // -----------------------------------------------------------------------
    // Gate window, per-fan accumulators, published counts and stall flags
    // -----------------------------------------------------------------------
    logic [GW-1:0]    gate_cnt;
    logic             gate_end;
    logic [5:0][15:0] acc;
    logic [5:0][15:0] acc_nxt;
    logic [5:0][15:0] tach_cnt;
    logic [5:0]       fault_nxt;

    always_comb begin
        gate_end  = (gate_cnt == GATE_LAST);
        acc_nxt   = '0;
        fault_nxt = '0;
        for (int i = 0; i < 6; i++) begin
            // An edge seen in the final window cycle still belongs to it.
            acc_nxt[i]   = sat16(acc[i], fall[i]);
            fault_nxt[i] = (acc_nxt[i] < i_min_cnt);
        end
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            gate_cnt     <= '0;
            acc          <= '0;
            tach_cnt     <= '0;
            o_fan_fault  <= '0;
            o_tach_valid <= 1'b0;
        end else begin
            o_tach_valid <= gate_end;
            if (gate_end) begin
                gate_cnt    <= '0;
                tach_cnt    <= acc_nxt;
                acc         <= '0;
                o_fan_fault <= fault_nxt;
            end else begin
                gate_cnt    <= gate_cnt + 1'b1;
                acc         <= acc_nxt;
            end
        end
    end

    assign o_tach_cnt = tach_cnt;

    // -----------------------------------------------------------------------
    // Software watchdog: counts closed windows since the last duty write.
    // A write in the same cycle as a window end takes priority.
    // -----------------------------------------------------------------------
    logic [WW-1:0] wdog_cnt;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            wdog_cnt       <= '0;
            o_wdog_expired <= 1'b0;
        end else if (i_duty_we) begin
            wdog_cnt       <= '0;
            o_wdog_expired <= 1'b0;
        end else if (gate_end && (wdog_cnt != WDOG_LIMIT)) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if ((wdog_cnt + 1'b1) == WDOG_LIMIT) begin
                o_wdog_expired <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fan_pwm_tach_ctrl.sv
// Bench for fan_pwm_tach_ctrl. The main instance uses a short PWM period
// (10 steps, 1 cycle each) and a 1000-cycle gate window; a second instance
// with a long window exercises count saturation.
module tb_fan_pwm_tach_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst_n;
    logic [7:0]  duty;
    logic        duty_we;
    logic [15:0] min_cnt;
    logic [5:0]  fan;
    logic        fan_pwm;
    logic [95:0] tach_cnt;
    logic        tach_valid;
    logic [5:0]  fan_fault;
    logic        wdog;

    // saturation instance
    logic        rst_s;
    logic [7:0]  duty_s;
    logic        we_s;
    logic [15:0] min_s;
    logic [5:0]  fan_s;
    logic        pwm_s;
    logic [95:0] cnt_s;
    logic        valid_s;
    logic [5:0]  fault_s;
    logic        wdog_s;

    fan_pwm_tach_ctrl #(
        .PWM_PRESCALE(1), .PWM_TOP(9), .GATE_CYCLES(1000), .WDOG_GATES(2)
    ) u_dut (
        .i_aclk(clk), .i_aresetn(rst_n), .i_duty(duty), .i_duty_we(duty_we),
        .i_min_cnt(min_cnt), .i_fan_speed(fan), .o_fan_pwm(fan_pwm),
        .o_tach_cnt(tach_cnt), .o_tach_valid(tach_valid),
        .o_fan_fault(fan_fault), .o_wdog_expired(wdog)
    );

    fan_pwm_tach_ctrl #(
        .PWM_PRESCALE(1), .PWM_TOP(9), .GATE_CYCLES(140100), .WDOG_GATES(3)
    ) u_sat (
        .i_aclk(clk), .i_aresetn(rst_s), .i_duty(duty_s), .i_duty_we(we_s),
        .i_min_cnt(min_s), .i_fan_speed(fan_s), .o_fan_pwm(pwm_s),
        .o_tach_cnt(cnt_s), .o_tach_valid(valid_s),
        .o_fan_fault(fault_s), .o_wdog_expired(wdog_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected window results
    typedef struct {
        string       name;
        logic [95:0] cnt;
        logic [5:0]  fault;
    } win_exp_t;

    win_exp_t sb[$];

    function automatic logic [95:0] pack6(input logic [15:0] c0, input logic [15:0] c1,
                                          input logic [15:0] c2, input logic [15:0] c3,
                                          input logic [15:0] c4, input logic [15:0] c5);
        return {c5, c4, c3, c2, c1, c0};
    endfunction

    function automatic win_exp_t mk_exp(input string n, input logic [95:0] c, input logic [5:0] f);
        win_exp_t e;
        e.name  = n;
        e.cnt   = c;
        e.fault = f;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        win_exp_t e;
        if (rst_n && tach_valid && (sb.size() > 0)) begin
            e = sb.pop_front();
            for (int i = 0; i < 6; i++) begin
                check($sformatf("%s cnt[%0d]", e.name, i),
                      32'(tach_cnt[16*i +: 16]), 32'(e.cnt[16*i +: 16]));
            end
            check($sformatf("%s fault", e.name), 32'(fan_fault), 32'(e.fault));
        end
    end

    // PWM vectors: duty written -> high cycles per 10-cycle period
    typedef struct {
        logic [7:0] d;
        int         high;
    } pwm_vec_t;

    pwm_vec_t pv[7];

    task automatic write_duty(input logic [7:0] d);
        @(negedge clk);
        duty    = d;
        duty_we = 1'b1;
        @(negedge clk);
        duty_we = 1'b0;
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(negedge clk);
            if (fan_pwm) h++;
        end
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (tach_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: o_tach_valid timeout got 0 expected 1", name);
        end
    endtask

    initial begin
        int h;
        int tgt[6];
        pv[0] = '{8'd3,   3};
        pv[1] = '{8'd0,   0};
        pv[2] = '{8'd200, 10};
        pv[3] = '{8'd10,  10};
        pv[4] = '{8'd9,   9};
        pv[5] = '{8'd1,   1};
        pv[6] = '{8'd5,   5};
        tgt   = '{37, 20, 15, 10, 12, 0};

        rst_n = 1'b0; duty = 8'd0; duty_we = 1'b0; min_cnt = 16'd10; fan = '0;
        rst_s = 1'b0; duty_s = 8'd0; we_s = 1'b0; min_s = 16'd10; fan_s = '0;
        sb.push_back(mk_exp("win1_idle", '0, 6'h3F));

        fork
            begin : main_seq
                repeat (3) @(negedge clk);
                check("pwm_in_reset", 32'(fan_pwm), 32'd1);
                rst_n = 1'b1;
                @(negedge clk);
                check("rst_pwm", 32'(fan_pwm), 32'd1);
                check("rst_tach_cnt", 32'(tach_cnt != 96'd0), 32'd0);
                check("rst_valid", 32'(tach_valid), 32'd0);
                check("rst_fault", 32'(fan_fault), 32'd0);
                check("rst_wdog", 32'(wdog), 32'd0);
                count_high(40, h);
                check("rst_pwm_full", 32'(h), 32'd40);

                for (int v = 0; v < 7; v++) begin
                    write_duty(pv[v].d);
                    repeat (25) @(negedge clk);
                    count_high(10, h);
                    check($sformatf("pwm_duty_%0d", pv[v].d), 32'(h), 32'(pv[v].high));
                end
                check("fault_before_first_window", 32'(fan_fault), 32'd0);

                wait_valid("win1");
                @(posedge clk);
                sb.push_back(mk_exp("win2_fans",
                    pack6(16'd37, 16'd20, 16'd15, 16'd10, 16'd12, 16'd0), 6'b100000));
                for (int j = 1; j <= 999; j++) begin
                    @(negedge clk);
                    for (int f = 0; f < 5; f++)
                        fan[f] = (j <= 2 * tgt[f]) ? j[0] : 1'b0;
                end

                wait_valid("win2");
                @(posedge clk);
                min_cnt = 16'd1;
                sb.push_back(mk_exp("win3_edge_at_end",
                    pack6(16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0), 6'b111011));
                for (int j = 1; j <= 999; j++) begin
                    @(negedge clk);
                    fan[2] = (j >= 994) && (j < 997);
                    fan[3] = (j >= 996) && (j < 998);
                end

                wait_valid("win3");
                @(posedge clk);
                sb.push_back(mk_exp("win4_edge_after_end",
                    pack6(16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0), 6'b110111));
                for (int j = 1; j <= 999; j++) begin
                    @(negedge clk);
                    if (j == 999) begin
                        duty    = 8'd3;
                        duty_we = 1'b1;
                    end
                end

                // duty write coincides with the window-4 end
                wait_valid("win4");
                duty_we = 1'b0;
                repeat (25) @(negedge clk);
                count_high(10, h);
                check("pwm_duty_3_before_wdog", 32'(h), 32'd3);

                wait_valid("win5");
                repeat (2) @(negedge clk);
                check("wdog_after_1_window", 32'(wdog), 32'd0);
                wait_valid("win6");
                repeat (2) @(negedge clk);
                check("wdog_after_2_windows", 32'(wdog), 32'd1);
                check("scoreboard_drained", 32'(sb.size()), 32'd0);

                repeat (25) @(negedge clk);
                count_high(10, h);
                check("pwm_forced_full", 32'(h), 32'd10);

                write_duty(8'd5);
                check("wdog_cleared_by_write", 32'(wdog), 32'd0);
                repeat (25) @(negedge clk);
                count_high(10, h);
                check("pwm_duty_5_after_wdog", 32'(h), 32'd5);

                for (int k = 0; k < 20; k++) begin
                    if (!fan_pwm) break;
                    @(negedge clk);
                end
                check("pwm_low_before_reset", 32'(fan_pwm), 32'd0);
                #1 rst_n = 1'b0;
                #1;
                check("midrst_pwm", 32'(fan_pwm), 32'd1);
                check("midrst_fault", 32'(fan_fault), 32'd0);
                check("midrst_wdog", 32'(wdog), 32'd0);
                check("midrst_valid", 32'(tach_valid), 32'd0);
                check("midrst_tach_cnt", 32'(tach_cnt != 96'd0), 32'd0);
                count_high(3, h);
                check("midrst_pwm_held", 32'(h), 32'd3);
                rst_n = 1'b1;
                count_high(20, h);
                check("post_rst_pwm_full", 32'(h), 32'd20);
            end

            begin : sat_seq
                bit ok;
                repeat (4) @(negedge clk);
                rst_s = 1'b1;
                for (int k = 0; k < 70000; k++) begin
                    @(negedge clk);
                    fan_s[1] = 1'b1;
                    @(negedge clk);
                    fan_s[1] = 1'b0;
                end
                ok = 1'b0;
                for (int k = 0; k < 300; k++) begin
                    @(negedge clk);
                    if (valid_s) begin
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL sat_valid: timeout got 0 expected 1");
                end
                check("sat_cnt1", 32'(cnt_s[31:16]), 32'h0000FFFF);
                check("sat_cnt0", 32'(cnt_s[15:0]), 32'd0);
                check("sat_fault", 32'(fault_s[1:0]), 32'd1);
                check("sat_pwm_default_full", 32'(pwm_s), 32'd1);
                check("sat_wdog", 32'(wdog_s), 32'd0);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
